// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DBG = 1'b1
    } src_e;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_DEPTH_DEF  = 256;
    localparam int CPU_STREAK_DEF = 4;
    localparam int STREAK_W       = 4;

endpackage

// File: rtl/dmem_arb_fair.sv
// Grant logic for the data-memory arbiter. The CPU normally wins a
// contested cycle, but after CPU_STREAK consecutive contested wins the
// debug port is let through once so it cannot be starved.
import dmem_arb_pkg::*;

module dmem_arb_fair #(
    parameter int CPU_STREAK = CPU_STREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dbg_req,
    output logic cpu_ready,
    output logic dbg_ready,
    output logic grant_valid,
    output src_e grant_src
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                contested;
    logic                dbg_turn;
    logic                grant_cpu;
    logic                grant_dbg;

    // Combinational grant; nothing is accepted while reset is asserted.
    always_comb begin
        contested = cpu_req & dbg_req;
        dbg_turn  = (streak == STREAK_MAX);
        grant_cpu = ~rst & cpu_req & ~(dbg_req & dbg_turn);
        grant_dbg = ~rst & dbg_req & (~cpu_req | dbg_turn);
    end

    assign cpu_ready   = grant_cpu;
    assign dbg_ready   = grant_dbg;
    assign grant_valid = grant_cpu | grant_dbg;
    assign grant_src   = grant_dbg ? SRC_DBG : SRC_CPU;

    // Count contested CPU wins; any debug grant or uncontested cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (contested && grant_cpu) begin
            if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end else begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and
// the debug port. Accept in cycle N, drive memory from the issue register
// in N+1, return registered read data in N+2.
// Optional build macro DMEM_ARB_RANGE_CHECK_EN: accesses at or beyond
// MEM_DEPTH never write, read back as zero, and set sticky range_err.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int CPU_STREAK = CPU_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic              range_err
`endif
);

    logic              grant_valid;
    src_e              grant_src;

    logic              iss_valid;
    logic              iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    src_e              iss_src;
    logic              iss_oor;
    logic [DATA_W-1:0] rd_data;

    dmem_arb_fair #(
        .CPU_STREAK (CPU_STREAK)
    ) u_fair (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .cpu_ready   (cpu_ready),
        .dbg_ready   (dbg_ready),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // Issue register: capture the granted access; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_we    <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
            iss_src   <= SRC_CPU;
        end else begin
            iss_valid <= grant_valid;
            if (grant_valid) begin
                if (grant_src == SRC_DBG) begin
                    iss_we    <= dbg_we;
                    iss_addr  <= dbg_addr;
                    iss_wdata <= dbg_wdata;
                end else begin
                    iss_we    <= cpu_we;
                    iss_addr  <= cpu_addr;
                    iss_wdata <= cpu_wdata;
                end
                iss_src <= grant_src;
            end
        end
    end

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
    assign iss_oor = (iss_addr >= DEPTH_A);

    // Sticky flag for any issued out-of-range access; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (iss_valid && iss_oor) begin
            range_err <= 1'b1;
        end
    end
`else
    assign iss_oor = 1'b0;
`endif

    // Gating the strobe with rst aborts a write sitting in issue when reset hits.
    assign mem_address    = iss_addr;
    assign mem_write_data = iss_wdata;
    assign mem_write      = iss_valid & iss_we & ~iss_oor & ~rst;
    assign rd_data        = iss_oor ? '0 : mem_read_data;

    // Read return: route captured memory data to the requester that issued it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= iss_valid & ~iss_we & (iss_src == SRC_CPU);
            dbg_rvalid <= iss_valid & ~iss_we & (iss_src == SRC_DBG);
            if (iss_valid && !iss_we && iss_src == SRC_CPU) begin
                cpu_rdata <= rd_data;
            end
            if (iss_valid && !iss_we && iss_src == SRC_DBG) begin
                dbg_rdata <= rd_data;
            end
        end
    end

endmodule
